// File: rtl/spi_adc_rx_multi_if.sv
// rtl/spi_adc_rx_multi_if.sv - SPI pins and word/status outputs of the multi-channel ADC receiver
interface spi_adc_rx_multi_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_WIDTH   = 4
);
    logic                  spi_clock_in;
    logic                  spi_data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CH_WIDTH-1:0]   channel_out;
    logic                  data_valid;
    logic                  frame_done;
    logic                  timeout_error;
    logic                  busy;

    modport master (
        output spi_clock_in, spi_data_in,
        input  data_out, channel_out, data_valid, frame_done, timeout_error, busy
    );

    modport slave (
        input  spi_clock_in, spi_data_in,
        output data_out, channel_out, data_valid, frame_done, timeout_error, busy
    );
endinterface

// File: rtl/spi_adc_rx_multi.sv
// rtl/spi_adc_rx_multi.sv - oversampling SPI slave receiver, frames of NUM_CHANNELS tagged words
module spi_adc_rx_multi #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int CH_WIDTH      = 4,
    parameter int MSB_FIRST     = 1,
    parameter int SAMPLE_RISING = 1,
    parameter int IDLE_TIMEOUT  = 511
) (
    input logic               clock,
    input logic               reset,
    spi_adc_rx_multi_if.slave bus
);
    localparam int                  BW        = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0]       WORD_BITS = BW'(DATA_WIDTH);
    localparam logic [BW-1:0]       ONE_BIT   = BW'(1);
    localparam logic [CH_WIDTH-1:0] LAST_CH   = CH_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [15:0]         TIMEOUT   = 16'(IDLE_TIMEOUT);
    localparam logic                IDLE_LVL  = (SAMPLE_RISING == 0);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t                state_q;
    logic                  sck_s1_q, sck_s2_q, sck_s3_q;
    logic                  sdi_s1_q, sdi_s2_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, first_d, data_q;
    logic [BW-1:0]         bitcnt_q;
    logic [CH_WIDTH-1:0]   chan_q, chan_out_q;
    logic [15:0]           idle_cnt_q;
    logic                  valid_q, frame_q, tout_q, busy_q;
    logic                  samp_edge;

    assign samp_edge = (SAMPLE_RISING != 0) ? (sck_s2_q & ~sck_s3_q) : (~sck_s2_q & sck_s3_q);

    // first_d restarts a word from an empty register so a leftover word never bleeds in
    always_comb begin
        shift_d = shift_q;
        first_d = '0;
        if (MSB_FIRST != 0) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], sdi_s2_q};
            first_d = {{(DATA_WIDTH-1){1'b0}}, sdi_s2_q};
        end else begin
            shift_d = {sdi_s2_q, shift_q[DATA_WIDTH-1:1]};
            first_d = {sdi_s2_q, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sck_s1_q   <= IDLE_LVL;
            sck_s2_q   <= IDLE_LVL;
            sck_s3_q   <= IDLE_LVL;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            chan_q     <= '0;
            idle_cnt_q <= '0;
            data_q     <= '0;
            chan_out_q <= '0;
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            tout_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sck_s1_q <= bus.spi_clock_in;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            sdi_s1_q <= bus.spi_data_in;
            sdi_s2_q <= sdi_s1_q;
            valid_q  <= 1'b0;
            frame_q  <= 1'b0;
            tout_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (samp_edge) begin
                        state_q    <= S_RECV;
                        busy_q     <= 1'b1;
                        shift_q    <= first_d;
                        bitcnt_q   <= ONE_BIT;
                        chan_q     <= '0;
                        idle_cnt_q <= '0;
                    end
                end
                S_RECV: begin
                    if (bitcnt_q == WORD_BITS) begin
                        data_q     <= shift_q;
                        chan_out_q <= chan_q;
                        valid_q    <= 1'b1;
                        if (chan_q == LAST_CH) begin
                            frame_q    <= 1'b1;
                            chan_q     <= '0;
                            bitcnt_q   <= '0;
                            idle_cnt_q <= '0;
                            state_q    <= S_DONE;
                        end else begin
                            chan_q <= chan_q + 1'b1;
                            if (samp_edge) begin
                                shift_q    <= first_d;
                                bitcnt_q   <= ONE_BIT;
                                idle_cnt_q <= '0;
                            end else begin
                                bitcnt_q   <= '0;
                                idle_cnt_q <= idle_cnt_q + 16'd1;
                            end
                        end
                    end else if (samp_edge) begin
                        // an edge beats an expiring counter in the same cycle
                        shift_q    <= shift_d;
                        bitcnt_q   <= bitcnt_q + 1'b1;
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q > TIMEOUT) begin
                        tout_q     <= 1'b1;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        shift_q    <= '0;
                        bitcnt_q   <= '0;
                        chan_q     <= '0;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    // the last bit's active phase must end before a new frame can start
                    if (sck_s2_q == IDLE_LVL) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out      = data_q;
    assign bus.channel_out   = chan_out_q;
    assign bus.data_valid    = valid_q;
    assign bus.frame_done    = frame_q;
    assign bus.timeout_error = tout_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_spi_adc_rx_multi.sv
// tb/tb_spi_adc_rx_multi.sv - bench for spi_adc_rx_multi across three parameter sets
module tb_spi_adc_rx_multi;
    logic clock;
    logic reset;

    typedef struct {
        int          src;
        logic [31:0] d;
        int          ch;
        int          fd;
        int          cyc;
    } ev_t;

    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int          cyc = 0;
    int          edge_cyc = 0;
    int          tcnt = 0;
    int          tcyc = 0;
    int          fd_alone = 0;
    int          total = 0;
    int          bad = 0;
    int          t0;
    logic [31:0] ws[4];
    logic [31:0] p;

    spi_adc_rx_multi_if #(.DATA_WIDTH(16), .CH_WIDTH(4)) if0 ();
    spi_adc_rx_multi_if #(.DATA_WIDTH(12), .CH_WIDTH(4)) if1 ();
    spi_adc_rx_multi_if #(.DATA_WIDTH(16), .CH_WIDTH(4)) if2 ();

    spi_adc_rx_multi #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .CH_WIDTH(4), .MSB_FIRST(1),
        .SAMPLE_RISING(1), .IDLE_TIMEOUT(511)) u0 (.clock(clock), .reset(reset), .bus(if0.slave));
    spi_adc_rx_multi #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .CH_WIDTH(4), .MSB_FIRST(0),
        .SAMPLE_RISING(1), .IDLE_TIMEOUT(511)) u1 (.clock(clock), .reset(reset), .bus(if1.slave));
    spi_adc_rx_multi #(.DATA_WIDTH(16), .NUM_CHANNELS(1), .CH_WIDTH(4), .MSB_FIRST(1),
        .SAMPLE_RISING(0), .IDLE_TIMEOUT(511)) u2 (.clock(clock), .reset(reset), .bus(if2.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (if0.data_valid) obs_q.push_back('{0, 32'(if0.data_out), int'(if0.channel_out), int'(if0.frame_done), cyc});
        if (if1.data_valid) obs_q.push_back('{1, 32'(if1.data_out), int'(if1.channel_out), int'(if1.frame_done), cyc});
        if (if2.data_valid) obs_q.push_back('{2, 32'(if2.data_out), int'(if2.channel_out), int'(if2.frame_done), cyc});
        if ((if0.frame_done && !if0.data_valid) || (if1.frame_done && !if1.data_valid) ||
            (if2.frame_done && !if2.data_valid)) fd_alone <= fd_alone + 1;
        if (if0.timeout_error || if1.timeout_error || if2.timeout_error) begin
            tcnt <= tcnt + 1;
            tcyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic idle_of(input int t);
        return (t == 2);
    endfunction

    task automatic drive(input int t, input logic c, input logic d);
        case (t)
            0:       begin if0.spi_clock_in = c; if0.spi_data_in = d; end
            1:       begin if1.spi_clock_in = c; if1.spi_data_in = d; end
            default: begin if2.spi_clock_in = c; if2.spi_data_in = d; end
        endcase
    endtask

    task automatic set_idle(input int t);
        drive(t, idle_of(t), 1'b0);
    endtask

    // idle phase then active phase; the idle->active transition is the sampling edge
    task automatic send_bit(input int t, input logic b, input int h);
        drive(t, idle_of(t), b);
        tick(h);
        drive(t, ~idle_of(t), b);
        edge_cyc = cyc;
        tick(h);
    endtask

    // a word's value is its bits in wire order; valid follows the last pin edge by 4 clocks
    task automatic send_word_exp(input int t, input logic [31:0] w, input int ch, input int fd, input int h);
        int wb;
        wb = (t == 1) ? 12 : 16;
        for (int i = 0; i < wb; i++) send_bit(t, (t == 1) ? w[i] : w[wb-1-i], h);
        exp_q.push_back('{t, w & ((32'd1 << wb) - 32'd1), ch, fd, edge_cyc + 4});
    endtask

    task automatic send_frame(input int t, input int h, input logic [31:0] fw[4]);
        int nch;
        nch = (t == 0) ? 4 : 1;
        for (int k = 0; k < nch; k++) send_word_exp(t, fw[k], k, (k == nch - 1) ? 1 : 0, h);
    endtask

    task automatic finish_frame(input int t, input string tag);
        tick(6);
        set_idle(t);
        tick(5);
        begin
            check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                check({tag, "_src"}, 32'(obs_q[i].src), 32'(exp_q[i].src));
                check({tag, "_data"}, obs_q[i].d, exp_q[i].d);
                check({tag, "_chan"}, 32'(obs_q[i].ch), 32'(exp_q[i].ch));
                check({tag, "_fdone"}, 32'(obs_q[i].fd), 32'(exp_q[i].fd));
                check({tag, "_latency"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
            end
            obs_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic rand_words();
        for (int k = 0; k < 4; k++) ws[k] = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        drive(2, 1'b1, 1'b0);
        tick(3);
        check("rst_data", 32'(if0.data_out), 0);
        check("rst_chan", 32'(if0.channel_out), 0);
        check("rst_valid", 32'(if0.data_valid), 0);
        check("rst_busy", 32'(if0.busy), 0);
        check("rst_tout", 32'(if0.timeout_error), 0);
        reset = 1'b0;
        tick(20);
        check("idle_high_no_start", 32'(if2.busy), 0);

        ws = '{32'hA5C3, 32'h0001, 32'h8000, 32'hFFFF};
        send_frame(0, 4, ws);
        tick(6);
        check("busy_sck_active", 32'(if0.busy), 1);
        finish_frame(0, "frame_a");
        check("busy_after_idle", 32'(if0.busy), 0);

        rand_words();
        ws[0] = 32'hFFFF;
        ws[1] = 32'h0000;
        send_frame(0, 2, ws);
        finish_frame(0, "clk_div4");

        ws[0] = 32'h5A3;
        send_frame(1, 4, ws);
        finish_frame(1, "lsb12_a");
        rand_words();
        send_frame(1, 3, ws);
        finish_frame(1, "lsb12_rand");

        ws[0] = 32'h1234;
        send_frame(2, 4, ws);
        finish_frame(2, "fall_a");
        rand_words();
        send_frame(2, 2, ws);
        finish_frame(2, "fall_rand");

        rand_words();
        send_word_exp(0, ws[0], 0, 0, 4);
        send_word_exp(0, ws[1], 1, 0, 4);
        p = $urandom;
        t0 = tcnt;
        for (int i = 0; i < 7; i++) send_bit(0, p[15-i], 4);
        tick(596);
        check("tout_pulses", 32'(tcnt - t0), 1);
        // 513 clocks after the detected edge, which lags the pin by 3 synchroniser clocks
        check("tout_cycle", 32'(tcyc - edge_cyc), 516);
        check("tout_hold_data", 32'(if0.data_out), ws[1] & 32'hFFFF);
        check("tout_hold_chan", 32'(if0.channel_out), 1);
        check("tout_busy", 32'(if0.busy), 0);
        finish_frame(0, "pre_tout");
        rand_words();
        send_frame(0, 4, ws);
        finish_frame(0, "after_tout");

        rand_words();
        send_word_exp(0, ws[0], 0, 0, 4);
        p = $urandom;
        t0 = tcnt;
        for (int i = 0; i < 9; i++) send_bit(0, p[15-i], 4);
        reset = 1'b1;
        set_idle(0);
        tick(1);
        check("midrst_data", 32'(if0.data_out), 0);
        check("midrst_chan", 32'(if0.channel_out), 0);
        check("midrst_busy", 32'(if0.busy), 0);
        check("midrst_valid", 32'(if0.data_valid), 0);
        tick(3);
        reset = 1'b0;
        tick(5);
        finish_frame(0, "pre_rst");
        rand_words();
        send_frame(0, 4, ws);
        finish_frame(0, "after_rst");
        check("midrst_no_tout", 32'(tcnt - t0), 0);

        t0 = tcnt;
        for (int i = 0; i < 13; i++) begin
            p = $urandom;
            drive(0, 1'b0, p[0]);
            tick(1 + (i % 2));
            drive(0, 1'b1, p[0]);
            tick(1);
        end
        tick(600);
        check("jitter_tout", 32'(tcnt - t0), 1);
        check("jitter_busy", 32'(if0.busy), 0);
        finish_frame(0, "jitter_words");
        tick(4);
        rand_words();
        send_frame(0, 4, ws);
        finish_frame(0, "recovered");
        check("frame_done_alone", 32'(fd_alone), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
